// File: rtl/alu_pkg.sv
// ALU execution unit shared definitions: alu_op encodings, R-type function
// codes, internal ALU control codes, FSM state type and the op decoder.
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_RTYPE = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_SLT   = 3'b101;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [4:0] {
        CTL_ADD, CTL_SUB, CTL_AND, CTL_OR, CTL_XOR, CTL_NOR,
        CTL_SLT, CTL_SLTU, CTL_SLL, CTL_SRL, CTL_SRA,
        CTL_MFHI, CTL_MFLO, CTL_MULT, CTL_MULTU, CTL_DIV, CTL_DIVU
    } alu_ctl_e;

    typedef enum logic [1:0] {
        ST_IDLE, ST_ITER, ST_FIX
    } alu_state_e;

    // Map the external op class / funct pair onto one internal control code;
    // anything unrecognised falls back to ADD.
    function automatic alu_ctl_e decode_ctl(input logic [2:0] op, input logic [5:0] fn);
        alu_ctl_e c;
        c = CTL_ADD;
        case (op)
            OP_AND: c = CTL_AND;
            OP_OR:  c = CTL_OR;
            OP_XOR: c = CTL_XOR;
            OP_SLT: c = CTL_SLT;
            OP_RTYPE: begin
                case (fn)
                    FN_SLL:           c = CTL_SLL;
                    FN_SRL:           c = CTL_SRL;
                    FN_SRA:           c = CTL_SRA;
                    FN_ADD, FN_ADDU:  c = CTL_ADD;
                    FN_SUB, FN_SUBU:  c = CTL_SUB;
                    FN_AND:           c = CTL_AND;
                    FN_OR:            c = CTL_OR;
                    FN_XOR:           c = CTL_XOR;
                    FN_NOR:           c = CTL_NOR;
                    FN_SLT:           c = CTL_SLT;
                    FN_SLTU:          c = CTL_SLTU;
                    FN_MFHI:          c = CTL_MFHI;
                    FN_MFLO:          c = CTL_MFLO;
                    FN_MULT:          c = CTL_MULT;
                    FN_MULTU:         c = CTL_MULTU;
                    FN_DIV:           c = CTL_DIV;
                    FN_DIVU:          c = CTL_DIVU;
                    default:          c = CTL_ADD;
                endcase
            end
            default: c = CTL_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, one bit per step, with the sign
// correction applied combinationally on the fix_hi/fix_lo outputs.
// Divider hardware is present only when ALU_DIV_EN is defined.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_signed,
`ifdef ALU_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic                      neg_a;
    logic                      neg_b;
    logic [WIDTH-1:0]          mag_a;
    logic [WIDTH-1:0]          mag_b;
    logic [WIDTH-1:0]          acc_q;   // HI half / partial remainder
    logic [WIDTH-1:0]          quo_q;   // LO half / multiplier / quotient
    logic [WIDTH-1:0]          opnd_q;  // multiplicand or divisor magnitude
    logic                      neg_q;   // product or quotient needs negation
    logic [WIDTH:0]            sum;
    logic [2*WIDTH-1:0]        prod;
`ifdef ALU_DIV_EN
    logic                      div_q;
    logic                      neg_rem_q;
    logic                      bzero_q;
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH:0]            shifted;
    logic [WIDTH:0]            trial;
`endif

    assign a_s   = a;
    assign b_s   = b;
    assign neg_a = is_signed & (a_s < 0);
    assign neg_b = is_signed & (b_s < 0);
    assign mag_a = neg_a ? -a : a;
    assign mag_b = neg_b ? -b : b;

    assign sum  = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    assign prod = neg_q ? -{acc_q, quo_q} : {acc_q, quo_q};
`ifdef ALU_DIV_EN
    assign shifted = {acc_q, quo_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, opnd_q};
`endif

    // Capture mode and sign-fix flags when an operation starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q     <= 1'b0;
`ifdef ALU_DIV_EN
            div_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
`endif
        end else if (start) begin
            neg_q     <= neg_a ^ neg_b;
`ifdef ALU_DIV_EN
            div_q     <= is_div;
            neg_rem_q <= neg_a;
            bzero_q   <= (b == '0);
`endif
        end
    end

    // Load magnitudes on start, then advance one multiply/divide bit per step.
    always_ff @(posedge clk) begin
        if (start) begin
            acc_q <= '0;
`ifdef ALU_DIV_EN
            quo_q  <= is_div ? mag_a : mag_b;
            opnd_q <= is_div ? mag_b : mag_a;
            a_q    <= a;
`else
            quo_q  <= mag_b;
            opnd_q <= mag_a;
`endif
        end else if (step) begin
`ifdef ALU_DIV_EN
            if (div_q) begin
                if (!trial[WIDTH]) begin
                    acc_q <= trial[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_q <= shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                acc_q <= sum[WIDTH:1];
                quo_q <= {sum[0], quo_q[WIDTH-1:1]};
            end
        end
    end

    // Apply sign correction (and the divide-by-zero convention) to the raw result.
    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
`ifdef ALU_DIV_EN
        if (div_q) begin
            if (bzero_q) begin
                fix_lo = '1;
                fix_hi = a_q;
            end else begin
                fix_lo = neg_q ? -quo_q : quo_q;
                fix_hi = neg_rem_q ? -acc_q : acc_q;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle add/sub/logic/shift/compare plus an
// iterative multiply/divide with HI/LO registers. Define ALU_DIV_EN to
// include the divider; without it DIV/DIVU complete in one cycle with 0.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e              state_q;
    alu_state_e              state_d;
    alu_ctl_e                ctl;
    logic                    rdy_q;
    logic [SHW-1:0]          cnt_q;
    logic [WIDTH-1:0]        hi_q;
    logic [WIDTH-1:0]        lo_q;
    logic [WIDTH-1:0]        result_q;
    logic                    out_valid_q;
    logic                    accept;
    logic                    is_md;
    logic                    md_signed;
    logic                    start_md;
    logic                    step_md;
    logic [SHW-1:0]          sh;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]        alu_res;
    logic [WIDTH-1:0]        fix_hi;
    logic [WIDTH-1:0]        fix_lo;
`ifdef ALU_DIV_EN
    logic                    md_div;
`endif

    assign ctl = decode_ctl(alu_op, funct);
`ifdef ALU_DIV_EN
    assign md_div    = (ctl == CTL_DIV) || (ctl == CTL_DIVU);
    assign is_md     = (ctl == CTL_MULT) || (ctl == CTL_MULTU) || md_div;
    assign md_signed = (ctl == CTL_MULT) || (ctl == CTL_DIV);
`else
    assign is_md     = (ctl == CTL_MULT) || (ctl == CTL_MULTU);
    assign md_signed = (ctl == CTL_MULT);
`endif

    assign in_ready  = rdy_q & (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = in_valid & in_ready;
    assign step_md   = (state_q == ST_ITER);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = out_valid_q & (result_q == '0);

    assign sh  = b[SHW-1:0];
    assign a_s = a;
    assign b_s = b;

    // Single-cycle result selection; DIV/DIVU land in the default when the divider is absent.
    always_comb begin
        alu_res = '0;
        case (ctl)
            CTL_ADD:  alu_res = a + b;
            CTL_SUB:  alu_res = a - b;
            CTL_AND:  alu_res = a & b;
            CTL_OR:   alu_res = a | b;
            CTL_XOR:  alu_res = a ^ b;
            CTL_NOR:  alu_res = ~(a | b);
            CTL_SLT:  alu_res = {{(WIDTH - 1){1'b0}}, (a_s < b_s)};
            CTL_SLTU: alu_res = {{(WIDTH - 1){1'b0}}, (a < b)};
            CTL_SLL:  alu_res = a << sh;
            CTL_SRL:  alu_res = a >> sh;
            CTL_SRA:  alu_res = a_s >>> sh;
            CTL_MFHI: alu_res = hi_q;
            CTL_MFLO: alu_res = lo_q;
            default:  alu_res = '0;
        endcase
    end

    // FSM next state: IDLE -> ITER on mult/div accept, WIDTH steps, one FIX cycle.
    always_comb begin
        state_d  = state_q;
        start_md = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_md) begin
                    state_d  = ST_ITER;
                    start_md = 1'b1;
                end
            end
            ST_ITER: begin
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; rdy_q holds off in_ready until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            cnt_q   <= (state_q == ST_ITER) ? cnt_q + 1'b1 : '0;
        end
    end

    // Result, HI/LO and out_valid: HI/LO commit only when a mult/div finishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == ST_FIX) begin
                hi_q        <= fix_hi;
                lo_q        <= fix_lo;
                result_q    <= fix_lo;
                out_valid_q <= 1'b1;
            end else if (accept && !is_md) begin
                result_q    <= alu_res;
                out_valid_q <= 1'b1;
            end
        end
    end

    alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_md),
        .step      (step_md),
        .is_signed (md_signed),
`ifdef ALU_DIV_EN
        .is_div    (md_div),
`endif
        .a         (a),
        .b         (b),
        .fix_hi    (fix_hi),
        .fix_lo    (fix_lo)
    );

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 Localparam SHW = log2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operation offered this cycle.
REQ-006 in_ready  output  1  unit accepts an operation this cycle.
REQ-007 alu_op  input  3  operation class; 000 ADD, 001 R-type (use funct), 010 AND, 011 OR, 100 XOR, 101 SLT, others ADD.
REQ-008 funct  input  6  R-type function code.
REQ-009 a, b  input  WIDTH  operands.
REQ-010 out_valid  output  1  one-cycle pulse; result valid.
REQ-011 result  output  WIDTH  registered result.
REQ-012 zero  output  1  result == 0, qualified by out_valid.
REQ-013 busy  output  1  iterative multiply/divide in progress.

Function
REQ-014 Accept = in_valid & in_ready; in_ready = (state == IDLE).
REQ-015 Single-cycle ops: out_valid exactly 1 cycle after accept.
REQ-016 R-type funct map: 00 SLL, 02 SRL, 03 SRA, 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT signed, 2B SLTU unsigned, 10 MFHI, 12 MFLO, 18 MULT, 19 MULTU, 1A DIV, 1B DIVU; unknown funct = ADD.
REQ-017 Add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-018 SLT/SLTU result is zero-extended 1-bit compare.
REQ-019 MULT/MULTU: radix-2 shift-add over WIDTH cycles; {HI,LO} = 2*WIDTH-bit product; signed via magnitude plus final sign fix.
REQ-020 DIV/DIVU: restoring division over WIDTH cycles; LO = quotient truncated toward zero, HI = remainder with dividend's sign.
REQ-021 Divide by zero: LO = all ones, HI = a; no exception.
REQ-022 Mult/div out_valid exactly WIDTH+2 cycles after accept; result = new LO.
REQ-023 FSM: IDLE -> ITER on mult/div accept; ITER -> FIX after WIDTH iterations; FIX -> IDLE with out_valid pulse.
REQ-024 busy = state in {ITER, FIX}; in_valid while busy ignored, no state change.
REQ-025 New op may be accepted in the cycle out_valid pulses for a mult/div (state is IDLE).
REQ-026 MFHI/MFLO accepted same cycle as mult/div completion read the new HI/LO.
REQ-027 HI/LO change only on mult/div completion or reset.

Reset
REQ-028 rst_n low at any time: state IDLE, busy 0, out_valid 0, result 0, HI 0, LO 0, iteration counter 0; in-flight operation discarded.
REQ-029 in_ready is 0 while rst_n is low and 1 from the first clock edge after release.

Configuration
REQ-030 Macro ALU_DIV_EN defined: DIV/DIVU behave per REQ-020..REQ-022.
REQ-031 Macro ALU_DIV_EN undefined: divider hardware omitted; DIV/DIVU complete as single-cycle ops, result 0, HI/LO unchanged.

Structure
REQ-032 Package alu_pkg holds alu_op encodings, funct codes, internal ALU control codes, and the FSM state enum.
REQ-033 Iterative multiply/divide datapath in one sub-module alu_iter_muldiv; shifts/logic/compare inline in alu_exec_unit.

Verification (WIDTH=32)
REQ-034 alu_op=001, funct=2B, a=FFFFFFFF, b=1 -> result 0; funct=2A same operands -> result 1.
REQ-035 MULT a=FFFFFFFD (-3), b=7 -> out_valid at cycle 34, result/LO FFFFFFEB, then MFHI -> FFFFFFFF.
REQ-036 DIV a=FFFFFFF9 (-7), b=2 -> LO FFFFFFFD, MFHI -> FFFFFFFF; DIVU a=5, b=0 -> LO FFFFFFFF, HI 5.
REQ-037 MULTU accepted, in_valid held with ADD during busy -> ADD ignored, in_ready 0 until mult out_valid, ADD accepted that cycle.
REQ-038 rst_n pulsed low 10 cycles into MULT -> busy 0, no out_valid, MFHI/MFLO after release return 0.
REQ-039 Build without ALU_DIV_EN, DIV a=8, b=2 -> out_valid after 1 cycle, result 0, HI/LO unchanged.
